// File: rtl/sseg_scan_controller.sv
// rtl/sseg_scan_controller.sv - four-digit multiplexed seven-segment scan controller
// Guard-banded anode scanning with leading-zero blanking and frame-aligned value updates.
module sseg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  digit,
    output logic [3:0]  sseg_anode,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] slot_nxt;
    logic [1:0]    pos;
    logic [0:0]    state;
    logic [0:0]    state_nxt;

    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pending;

    logic          slot_end;
    logic          frame_end;
    logic          commit;
    logic [3:0]    cur_nib;
    logic          blank;
    logic [3:0]    anode_nxt;
    logic          dp_nxt;

    always_comb begin
        slot_end  = (slot_cnt == SLOT_LAST);
        frame_end = slot_end && (pos == 2'd3);
        commit    = frame_end && (pending || load);
        slot_nxt  = slot_end ? '0 : slot_cnt + CW'(1);
        // State tracks the counter value it is paired with, so it is derived from slot_nxt.
        state_nxt = (slot_nxt < GUARD_END) ? ST_GUARD : ST_DRIVE;
        cur_nib   = shadow_val[{pos, 2'b00} +: 4];
    end

    // A position is blanked only if it and every more significant nibble are zero.
    always_comb begin
        blank = 1'b0;
        case (pos)
            2'd1:    blank = lzb_en && (shadow_val[15:4] == 12'h000);
            2'd2:    blank = lzb_en && (shadow_val[15:8] == 8'h00);
            2'd3:    blank = lzb_en && (shadow_val[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    always_comb begin
        anode_nxt = 4'b1111;
        dp_nxt    = 1'b1;
        if (state == ST_DRIVE && !blank) begin
            anode_nxt[pos] = 1'b0;
            dp_nxt         = ~shadow_dp[pos];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            pos        <= 2'd0;
            state      <= ST_GUARD;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pending    <= 1'b0;
            digit      <= 4'h0;
            sseg_anode <= 4'b1111;
            dp_n       <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            slot_cnt <= slot_nxt;
            state    <= state_nxt;
            if (slot_end) begin
                pos <= pos + 2'd1;
            end

            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end

            // A load on the boundary cycle itself goes straight into this commit.
            if (commit) begin
                pending    <= 1'b0;
                shadow_val <= load ? value : pend_val;
                shadow_dp  <= load ? dp_in : pend_dp;
            end else if (load) begin
                pending <= 1'b1;
            end

            digit      <= cur_nib;
            sseg_anode <= anode_nxt;
            dp_n       <= dp_nxt;
            load_ack   <= commit;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb/tb_sseg_scan_controller.sv - scoreboard bench for sseg_scan_controller
// Stimulus queues per-slot and per-frame expectations; a negedge monitor pops and compares.
module tb_sseg_scan_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        lzb_en = 1'b0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [3:0]  digit;
    logic [3:0]  sseg_anode;
    logic        dp_n;
    logic        frame_done;

    sseg_scan_controller #(
        .REFRESH_DIV (8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .value     (value),
        .dp_in     (dp_in),
        .lzb_en    (lzb_en),
        .load      (load),
        .load_ack  (load_ack),
        .digit     (digit),
        .sseg_anode(sseg_anode),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dg;
        logic       dpn;
    } slot_t;

    slot_t exp_slots[$];
    logic  exp_frames[$];
    int    checks = 0;
    int    errors = 0;
    int    ucnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // an/dg are four nibbles with position 0 in the low nibble; dpn bit i is dp_n of position i.
    task automatic push_frame(input logic [15:0] an, input logic [15:0] dg,
                              input logic [3:0] dpn, input logic ack);
        slot_t s;
        for (int i = 0; i < 4; i++) begin
            s.an  = an[4*i +: 4];
            s.dg  = dg[4*i +: 4];
            s.dpn = dpn[i];
            exp_slots.push_back(s);
        end
        exp_frames.push_back(ack);
    endtask

    // Counts posedges since reset release; at a negedge the outputs reflect state time ucnt-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ucnt <= 0;
        else          ucnt <= ucnt + 1;
    end

    always @(negedge clk) begin : monitor
        int    o;
        int    ph;
        slot_t s;
        if (reset_n && ucnt >= 1) begin
            o  = ucnt - 1;
            ph = o % 8;
            if (ph < 2) begin
                chk("guard_anode", 32'(sseg_anode), 32'hF);
                chk("guard_dp_n", 32'(dp_n), 32'h1);
                if (exp_slots.size() > 0) chk("guard_digit", 32'(digit), 32'(exp_slots[0].dg));
            end else if (exp_slots.size() == 0) begin
                chk("slot_queue_underflow", 32'(exp_slots.size()), 32'h1);
            end else begin
                s = exp_slots[0];
                chk("drive_anode", 32'(sseg_anode), 32'(s.an));
                chk("drive_digit", 32'(digit), 32'(s.dg));
                chk("drive_dp_n", 32'(dp_n), 32'(s.dpn));
                if (ph == 7) void'(exp_slots.pop_front());
            end
            chk("frame_done", 32'(frame_done), 32'((o % 32) == 31));
            if ((o % 32) == 31) begin
                if (exp_frames.size() == 0) chk("frame_queue_underflow", 32'(exp_frames.size()), 32'h1);
                else                        chk("load_ack_frame", 32'(load_ack), 32'(exp_frames.pop_front()));
            end else begin
                chk("load_ack_idle", 32'(load_ack), 32'h0);
            end
        end
    end

    task automatic wait_ucnt(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ucnt != n && guard < 2000);
        if (ucnt != n) chk("wait_timeout", 32'(ucnt), 32'(n));
    endtask

    task automatic do_load(input int at, input logic [15:0] v, input logic [3:0] d);
        wait_ucnt(at);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        push_frame(16'h7BDE, 16'h0000, 4'b1111, 1'b1);
        push_frame(16'h7BDE, 16'h12AF, 4'b1011, 1'b0);
        push_frame(16'h7BDE, 16'h12AF, 4'b1011, 1'b1);
        push_frame(16'hFFFE, 16'h0005, 4'b1111, 1'b1);
        push_frame(16'hFFFE, 16'h0000, 4'b1110, 1'b1);
        push_frame(16'h7BDE, 16'h2222, 4'b1111, 1'b1);
        push_frame(16'h7BDE, 16'h3456, 4'b1110, 1'b0);

        #12;
        chk("reset_anode", 32'(sseg_anode), 32'hF);
        chk("reset_digit", 32'(digit), 32'h0);
        chk("reset_dp_n", 32'(dp_n), 32'h1);
        chk("reset_load_ack", 32'(load_ack), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        do_load(10, 16'h12AF, 4'b0100);
        wait_ucnt(64);
        lzb_en = 1'b1;
        do_load(70, 16'h0005, 4'b0000);
        do_load(100, 16'h0000, 4'b1111);
        do_load(130, 16'h1111, 4'b0000);
        do_load(140, 16'h2222, 4'b0000);
        wait_ucnt(160);
        lzb_en = 1'b0;
        do_load(191, 16'h3456, 4'b0001);
        do_load(200, 16'h9999, 4'b1111);

        wait_ucnt(213);
        #1;
        chk("pre_reset_anode_pos2", 32'(sseg_anode), 32'hB);
        reset_n = 1'b0;
        #1;
        chk("async_reset_anode", 32'(sseg_anode), 32'hF);
        chk("async_reset_digit", 32'(digit), 32'h0);
        chk("async_reset_dp_n", 32'(dp_n), 32'h1);
        chk("async_reset_load_ack", 32'(load_ack), 32'h0);
        repeat (3) @(negedge clk);
        exp_slots.delete();
        exp_frames.delete();
        push_frame(16'h7BDE, 16'h0000, 4'b1111, 1'b0);
        push_frame(16'h7BDE, 16'h0000, 4'b1111, 1'b0);
        reset_n = 1'b1;

        wait_ucnt(66);
        chk("slots_drained", 32'(exp_slots.size()), 32'h0);
        chk("frames_drained", 32'(exp_frames.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_controller.md
SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter GUARD_CYCLES, default 1000, cycles at slot start with all anodes off (legal range 1..REFRESH_DIV-2).
REQ-003 SHALL have port clk, input, 1, the single system clock (all logic on rising edge).
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port value, input, 16, four hex nibbles; nibble i drives digit position i (0 = rightmost).
REQ-006 SHALL have port dp_in, input, 4, decimal point request per position, active-high.
REQ-007 SHALL have port lzb_en, input, 1, leading-zero blanking enable.
REQ-008 SHALL have port load, input, 1, request to capture value/dp_in.
REQ-009 SHALL have port load_ack, output, 1, one-cycle pulse when the pending request is committed to display.
REQ-010 SHALL have port digit, output, 4, nibble sent to the hex-to-cathode decoder.
REQ-011 SHALL have port sseg_anode, output, 4, anode enables, active-low, bit i = position i.
REQ-012 SHALL have port dp_n, output, 1, decimal point cathode, active-low.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at end of each 4-digit frame.

Function
REQ-014 SHALL keep slot_cnt (0..REFRESH_DIV-1) and pos (0..3); slot_cnt wraps to 0 after REFRESH_DIV-1, and pos increments on that wrap, 3 wrapping to 0.
REQ-015 SHALL run FSM GUARD -> DRIVE -> GUARD: GUARD while slot_cnt < GUARD_CYCLES, DRIVE for the rest of the slot.
REQ-016 SHALL register all outputs; outputs reflect the state/counter values of the previous cycle (1-cycle latency).
REQ-017 SHALL drive sseg_anode = 4'b1111 and dp_n = 1 in GUARD; in DRIVE it SHALL clear only bit pos, unless pos is blanked.
REQ-018 SHALL drive digit from the shadow nibble pos during both GUARD and DRIVE, so the decoder settles before anode turn-on.
REQ-019 SHALL blank position i (anode held 1, dp_n held 1) when lzb_en=1, i>0, and shadow nibbles i..3 are all zero; position 0 SHALL never be blanked.
REQ-020 SHALL drive dp_n = ~shadow_dp[pos] in DRIVE for an unblanked position.
REQ-021 SHALL capture value/dp_in into a pending register and set pending whenever load=1; a later load before commit overwrites the pending data without an extra ack.
REQ-022 SHALL commit pending data to shadow only at frame boundary (pos=3, slot_cnt=REFRESH_DIV-1), clear pending, and pulse load_ack and frame_done together on the next cycle.
REQ-023 SHALL treat load=1 on the boundary cycle itself as included in that commit (new data used, one ack).
REQ-024 SHALL pulse frame_done at every frame boundary, whether or not a commit occurs; load_ack SHALL pulse only when committing.
REQ-025 SHALL sample lzb_en live each cycle; no capture is required.

Reset
REQ-026 SHALL, while reset_n=0, force slot_cnt=0, pos=0, state GUARD, shadow/pending data 0, pending=0, sseg_anode=4'b1111, digit=0, dp_n=1, load_ack=0, frame_done=0.
REQ-027 SHALL on reset assertion mid-slot or mid-request drop all anodes immediately and discard the pending request with no ack.
REQ-028 SHALL start the first slot at pos 0 with slot_cnt=0 after reset release.

Verification (REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-029 Reset release, no load -> anodes 1111 for 2 cycles then 1110 for 6, digit=0; pattern 1101/1011/0111 follows; frame_done every 32 cycles.
REQ-030 load once with value=16'h12AF, dp_in=4'b0100 -> load_ack with next frame_done; next frame digit sequence F,A,2,1; dp_n=0 only while anode=1011.
REQ-031 lzb_en=1, value=16'h0005 committed -> only anode 1110 ever active; value=16'h0000 -> only position 0 shows 0.
REQ-032 load 16'h1111, then 16'h2222 before boundary -> one load_ack; displayed digits all 2.
REQ-033 load=1 exactly on the boundary cycle -> ack and frame_done on the same cycle, new data in the following frame.
REQ-034 reset_n low during DRIVE of pos 2 with pending set -> anodes 1111 asynchronously; after release no load_ack, shadow=0, scan restarts at pos 0.
